// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between the icache and dcache miss paths.
// One line transaction in flight at a time, sequenced through command, write-data and response phases.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req_valid,
    input  logic [ADDR_W-1:0]     ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_resp_valid,
    output logic [DATA_W-1:0]     ic_resp_data,
    input  logic                  dc_req_valid,
    input  logic                  dc_req_rw,
    input  logic [ADDR_W-1:0]     dc_req_addr,
    input  logic [DATA_W-1:0]     dc_req_wdata,
    input  logic [DATA_W/8-1:0]   dc_req_wmask,
    output logic                  dc_req_ready,
    output logic                  dc_resp_valid,
    output logic [DATA_W-1:0]     dc_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_data_valid,
    input  logic                  mem_req_data_ready,
    output logic [DATA_W-1:0]     mem_req_data_bits,
    output logic [DATA_W/8-1:0]   mem_req_data_mask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data,
    output logic                  busy,
    output logic                  err_spurious
);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic                  last_dc;
    logic                  owner_dc;
    logic                  rw_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wmask_q;
    logic                  gnt_ic;
    logic                  gnt_dc;
    logic                  accept;

    // On a tie the requester that did not win last time gets the grant.
    assign gnt_dc = dc_req_valid & (~ic_req_valid | ~last_dc);
    assign gnt_ic = ic_req_valid & ~gnt_dc;
    assign accept = (state == IDLE) & (gnt_ic | gnt_dc);

    assign mem_req_rw        = rw_q;
    assign mem_req_addr      = addr_q;
    assign mem_req_data_bits = wdata_q;
    assign mem_req_data_mask = wmask_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CMD;
            CMD:     if (mem_req_ready) state_next = rw_q ? WDATA : RESP;
            WDATA:   if (mem_req_data_ready) state_next = IDLE;
            RESP:    if (mem_resp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        busy               = 1'b1;
        case (state)
            IDLE: begin
                busy         = 1'b0;
                ic_req_ready = gnt_ic;
                dc_req_ready = gnt_dc;
            end
            CMD:     mem_req_valid      = 1'b1;
            WDATA:   mem_req_data_valid = 1'b1;
            default: ;
        endcase
    end

    // Requester fields are captured once at accept; later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dc  <= 1'b0;
            owner_dc <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else if (accept) begin
            last_dc  <= gnt_dc;
            owner_dc <= gnt_dc;
            rw_q     <= gnt_dc & dc_req_rw;
            addr_q   <= gnt_dc ? dc_req_addr : ic_req_addr;
            wdata_q  <= gnt_dc ? dc_req_wdata : '0;
            wmask_q  <= gnt_dc ? dc_req_wmask : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ic_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            dc_resp_valid <= 1'b0;
            dc_resp_data  <= '0;
            err_spurious  <= 1'b0;
        end else begin
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            if (state == WDATA && mem_req_data_ready) begin
                dc_resp_valid <= 1'b1;
                dc_resp_data  <= '0;
            end
            if (state == RESP && mem_resp_valid) begin
                if (owner_dc) begin
                    dc_resp_valid <= 1'b1;
                    dc_resp_data  <= mem_resp_data;
                end else begin
                    ic_resp_valid <= 1'b1;
                    ic_resp_data  <= mem_resp_data;
                end
            end
            // Responses outside RESP are dropped and flagged until the next reset.
            if (state != RESP && mem_resp_valid) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory side driven by tasks, responses checked against a scoreboard queue.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int MASK_W = DATA_W / 8;

    logic                clk;
    logic                reset;
    logic                ic_req_valid;
    logic [ADDR_W-1:0]   ic_req_addr;
    logic                ic_req_ready;
    logic                ic_resp_valid;
    logic [DATA_W-1:0]   ic_resp_data;
    logic                dc_req_valid;
    logic                dc_req_rw;
    logic [ADDR_W-1:0]   dc_req_addr;
    logic [DATA_W-1:0]   dc_req_wdata;
    logic [MASK_W-1:0]   dc_req_wmask;
    logic                dc_req_ready;
    logic                dc_resp_valid;
    logic [DATA_W-1:0]   dc_resp_data;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_rw;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_req_data_valid;
    logic                mem_req_data_ready;
    logic [DATA_W-1:0]   mem_req_data_bits;
    logic [MASK_W-1:0]   mem_req_data_mask;
    logic                mem_resp_valid;
    logic [DATA_W-1:0]   mem_resp_data;
    logic                busy;
    logic                err_spurious;

    typedef struct packed {
        logic              dc;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_wmask(dc_req_wmask), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
        .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .busy(busy), .err_spurious(err_spurious)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and retire any response pulse against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (ic_resp_valid || dc_resp_valid) begin
            chk("sb_pending", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("resp_ic_valid", ic_resp_valid, !e.dc);
                chk("resp_dc_valid", dc_resp_valid, e.dc);
                chk("resp_data", e.dc ? dc_resp_data : ic_resp_data, e.data);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, err_spurious, 1'b0);
        chk({tag, "_valids"}, {ic_resp_valid, dc_resp_valid, mem_req_valid, mem_req_data_valid}, 4'b0);
        chk({tag, "_readys"}, {ic_req_ready, dc_req_ready}, 2'b0);
        chk({tag, "_mem_fields"}, {mem_req_rw, mem_req_addr, mem_req_data_mask}, '0);
        chk({tag, "_wdata"}, mem_req_data_bits, '0);
        chk({tag, "_resp_data"}, ic_resp_data | dc_resp_data, '0);
    endtask

    task automatic accept(input logic exp_dc, input string tag);
        #1;
        chk({tag, "_ic_ready"}, ic_req_ready, !exp_dc);
        chk({tag, "_dc_ready"}, dc_req_ready, exp_dc);
        step();
    endtask

    // Plays the memory side of one transaction, starting in the cycle after accept.
    task automatic serve(input logic exp_dc, input logic exp_rw, input logic [ADDR_W-1:0] exp_addr,
                         input logic [DATA_W-1:0] exp_wdata, input logic [MASK_W-1:0] exp_wmask,
                         input int cmd_stall, input int data_stall, input int resp_wait,
                         input logic [DATA_W-1:0] rdata);
        for (int i = 0; i < cmd_stall; i++) begin
            chk("cmd_valid_hold", mem_req_valid, 1'b1);
            chk("cmd_fields_hold", {mem_req_rw, mem_req_addr}, {exp_rw, exp_addr});
            step();
        end
        mem_req_ready = 1'b1;
        chk("cmd_valid", mem_req_valid, 1'b1);
        chk("cmd_rw", mem_req_rw, exp_rw);
        chk("cmd_addr", mem_req_addr, exp_addr);
        chk("busy_cmd", busy, 1'b1);
        chk("readys_busy", {ic_req_ready, dc_req_ready}, 2'b0);
        step();
        mem_req_ready = 1'b0;
        chk("cmd_dropped", mem_req_valid, 1'b0);
        if (exp_rw) begin
            for (int i = 0; i < data_stall; i++) begin
                chk("wdata_valid_hold", mem_req_data_valid, 1'b1);
                chk("wdata_bits_hold", mem_req_data_bits, exp_wdata);
                chk("wdata_mask_hold", mem_req_data_mask, exp_wmask);
                step();
            end
            mem_req_data_ready = 1'b1;
            chk("wdata_valid", mem_req_data_valid, 1'b1);
            chk("wdata_bits", mem_req_data_bits, exp_wdata);
            chk("wdata_mask", mem_req_data_mask, exp_wmask);
            exp_q.push_back('{dc: 1'b1, data: '0});
            step();
            mem_req_data_ready = 1'b0;
        end else begin
            for (int i = 0; i < resp_wait; i++) begin
                chk("resp_wait_busy", busy, 1'b1);
                chk("resp_wait_no_wdata", mem_req_data_valid, 1'b0);
                step();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = rdata;
            exp_q.push_back('{dc: exp_dc, data: rdata});
            step();
            mem_resp_valid = 1'b0;
        end
        chk("resp_seen", exp_q.size(), 0);
        chk("busy_after", busy, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] wpat;
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_wdata = '0; dc_req_wmask = '0;
        mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        reset = 1'b1;
        #2;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        step();

        // IC read alone, response one cycle after entering RESP
        ic_req_valid = 1'b1; ic_req_addr = 32'h1000;
        accept(1'b0, "t1_accept");
        ic_req_valid = 1'b0;
        serve(1'b0, 1'b0, 32'h1000, '0, '0, 0, 0, 1, {32'hDEADBEEF, 64'h0, 32'h0000_0001});
        step();

        // Tie after reset: DC first, then strict alternation
        reset = 1'b1; step(); reset = 1'b0; step();
        ic_req_valid = 1'b1; ic_req_addr = 32'h0100;
        dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 32'h0200;
        for (int i = 0; i < 4; i++) begin
            logic odd_dc;
            odd_dc = (i % 2 == 0);
            accept(odd_dc, "t2_accept");
            serve(odd_dc, 1'b0, odd_dc ? 32'h0200 : 32'h0100, '0, '0, 0, 0, 0,
                  {32'hCAFE0000 + 32'(i), 96'h5A5A});
        end
        ic_req_valid = 1'b0; dc_req_valid = 1'b0;
        step();

        // DC write with command and data back-pressure; inputs changed after accept
        wpat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 32'h2040;
        dc_req_wdata = wpat; dc_req_wmask = 16'hFFFF;
        accept(1'b1, "t3_accept");
        dc_req_valid = 1'b0; dc_req_wdata = ~wpat; dc_req_wmask = 16'h0; dc_req_addr = 32'h0;
        serve(1'b1, 1'b1, 32'h2040, wpat, 16'hFFFF, 5, 3, 0, '0);
        dc_req_rw = 1'b0;
        step();

        // Spurious response in IDLE
        chk("t4_err_before", err_spurious, 1'b0);
        mem_resp_valid = 1'b1; mem_resp_data = 128'hBAD;
        step();
        mem_resp_valid = 1'b0;
        chk("t4_err_set", err_spurious, 1'b1);
        step();
        chk("t4_err_sticky", err_spurious, 1'b1);
        ic_req_valid = 1'b1; ic_req_addr = 32'h0440;
        accept(1'b0, "t4_accept");
        ic_req_valid = 1'b0;
        serve(1'b0, 1'b0, 32'h0440, '0, '0, 1, 0, 2, 128'h1111_2222_3333_4444);
        chk("t4_err_still", err_spurious, 1'b1);

        // Reset while a DC read waits for its response
        dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 32'h0500;
        accept(1'b1, "t5_accept");
        dc_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("t5_in_resp", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("t5_reset");
        step();
        reset = 1'b0;
        step();
        mem_resp_valid = 1'b1; mem_resp_data = 128'h7777;
        step();
        mem_resp_valid = 1'b0;
        chk("t5_late_resp_err", err_spurious, 1'b1);
        ic_req_valid = 1'b1; ic_req_addr = 32'h0600;
        dc_req_valid = 1'b1; dc_req_addr = 32'h0700;
        accept(1'b1, "t5_tie");
        ic_req_valid = 1'b0; dc_req_valid = 1'b0;
        serve(1'b1, 1'b0, 32'h0700, '0, '0, 0, 0, 0, 128'h8888_9999);
        step();

        // Address change after accept has no effect
        ic_req_valid = 1'b1; ic_req_addr = 32'h3000;
        accept(1'b0, "t6_accept");
        ic_req_addr = 32'hFFFF;
        serve(1'b0, 1'b0, 32'h3000, '0, '0, 2, 0, 1, 128'hABCD_EF01);
        ic_req_valid = 1'b0;
        step();
        step();
        chk("sb_empty_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single backing-memory port between the instruction-cache and data-cache miss paths of the Riscv151 core. Accepts at most one outstanding line transaction at a time. Grants requesters round-robin and sequences each grant through command, write-data and response phases. Returns the memory response to the requester that owns the grant. Sits between the two cache miss handlers and the memory model/interconnect.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 128, line data width; must be a multiple of 8
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- ic_req_valid  input  1  icache read request
- ic_req_addr  input  ADDR_W  icache line address
- ic_req_ready  output  1  icache request accepted this cycle (when valid)
- ic_resp_valid  output  1  one-cycle pulse, read data valid
- ic_resp_data  output  DATA_W  read data
- dc_req_valid  input  1  dcache request
- dc_req_rw  input  1  1 = write, 0 = read
- dc_req_addr  input  ADDR_W  dcache line address
- dc_req_wdata  input  DATA_W  write data
- dc_req_wmask  input  DATA_W/8  byte write mask
- dc_req_ready  output  1  dcache request accepted this cycle (when valid)
- dc_resp_valid  output  1  one-cycle pulse: read data valid, or write ack
- dc_resp_data  output  DATA_W  read data; 0 on write ack
- mem_req_valid / mem_req_ready  output / input  1  command handshake
- mem_req_rw  output  1  command type
- mem_req_addr  output  ADDR_W  command address
- mem_req_data_valid / mem_req_data_ready  output / input  1  write-data handshake
- mem_req_data_bits  output  DATA_W  write data
- mem_req_data_mask  output  DATA_W/8  write mask
- mem_resp_valid  input  1  read response
- mem_resp_data  input  DATA_W  read response data
- busy  output  1  state != IDLE
- err_spurious  output  1  sticky: mem_resp_valid arrived outside RESP

## Operation
- FSM states: IDLE, CMD, WDATA, RESP.
- **IDLE**
  - Grant is combinational from the valids and the round-robin pointer `last` (IC/DC).
  - Only one valid: that requester wins.
  - Both valid: the requester opposite to `last` wins.
  - The winner's req_ready is high and the loser's is low. Both readys are low outside IDLE.
  - Handshake (valid & ready): latch owner, rw (IC forces 0), addr, wdata, wmask. Set `last` to the owner. Go to CMD.
- **CMD**
  - mem_req_valid=1, with rw/addr driven from the latched fields.
  - On mem_req_ready: go to WDATA if rw=1, else to RESP.
- **WDATA**
  - mem_req_data_valid=1, with bits/mask from the latched fields.
  - On mem_req_data_ready: register a dc_resp_valid pulse with data 0, and go to IDLE.
- **RESP**
  - Wait for mem_resp_valid.
  - When it arrives: register mem_resp_data into the owner's resp_data, pulse the owner's resp_valid for one cycle, and go to IDLE.
- **Spurious responses:** mem_resp_valid in any state other than RESP is ignored, and sets err_spurious. Only reset clears err_spurious.
- **Data holding:** resp_data holds its last value between pulses. The non-owner's resp_valid stays 0.
- **Requester inputs:** requester inputs are sampled only on the accept cycle. Changes to them afterwards have no effect.
- **Combinational path:** there is a combinational path from req_valid to req_ready. Requesters must not derive valid from ready.

## Timing
- **Reset (async):** state=IDLE, last=IC (so DC wins the first tie). All valid/ready outputs are 0, all data/addr outputs are 0, busy=0, err_spurious=0.
- **Reset mid-transaction:** the transaction is abandoned. No resp pulse is issued, and a later mem_resp_valid sets err_spurious.
- **Read, zero-wait memory:**
  - Accept at T.
  - mem_req_valid at T+1.
  - mem_resp_valid sampled at T+2.
  - resp_valid at T+3, in IDLE at T+3. The next accept is possible at T+3.
- **Write, zero-wait memory:**
  - Accept at T.
  - CMD at T+1.
  - WDATA at T+2.
  - dc_resp_valid at T+3, next accept at T+3.
- **Sustained contention:** grants strictly alternate IC, DC, IC, ...
- **Throughput:** at most one transaction in flight, so there is a minimum 3-cycle spacing between accepts.
- **Back-pressure:** mem_req_valid and its fields hold stable until mem_req_ready. The same holds for data_valid until data_ready.
- **mem_resp_valid in the same cycle as the CMD handshake:** spurious. The state is still CMD, so err_spurious is set and the response is dropped.

## Test plan
1. **IC read alone.**
   - Stimulus: ic_req_valid with addr 0x1000; memory returns 0xDEADBEEF_…_0001 two cycles after the command.
   - Required response: ic_req_ready=1 at T; mem_req_addr=0x1000 with rw=0 at T+1; ic_resp_valid for exactly one cycle with the matching data; dc_resp_valid stays 0.
2. **Tie after reset.**
   - Stimulus: both requesters valid continuously for 4 transactions.
   - Required response: grant order DC, IC, DC, IC; each resp is routed only to its owner.
3. **DC write with stalls.**
   - Stimulus: dc write to addr 0x2040, mask 0xFFFF, wdata pattern; mem_req_ready low 5 cycles, then mem_req_data_ready low 3 cycles.
   - Required response: fields stable throughout; dc_resp_valid=1 with data 0 on the cycle after the data handshake; busy=0 afterwards.
4. **Spurious response.**
   - Stimulus: mem_resp_valid pulsed in IDLE.
   - Required response: err_spurious=1 and stays 1; no resp pulse; the next read completes normally.
5. **Reset mid-RESP.**
   - Stimulus: assert reset while waiting on the response of a DC read.
   - Required response: outputs are immediately at reset values, with no resp pulse; the post-reset tie goes to DC.
6. **Input change after accept.**
   - Stimulus: after acceptance, change ic_req_addr to 0xFFFF.
   - Required response: mem_req_addr still shows the originally accepted address.
